fcmp_sched: RTL and testbench
=============================

Name: fcmp_sched

Overview:
- Shared floating-point compare unit (feq/flt/fle, single precision) with NREQ requester ports and one result port.
- Round-robin arbitration selects one requester per cycle, and the chosen compare is computed and registered.
- The result is held until the consumer accepts it.
- Sits between the core's issue stage (plus auxiliary requesters) and the FPU writeback mux, so one compare datapath serves all requesters.

Parameters:
- NREQ, 4, number of requester ports (2..8).
- IDW, 2, width of requester index; must equal $clog2(NREQ).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant; request i is accepted when req_valid[i] && req_ready[i].
- req_op  input  2*NREQ  per-requester op, slice [2i+1:2i]: 00 feq, 01 flt, 10 fle, 11 reserved (result 0).
- req_x1  input  32*NREQ  operand 1, slice [32i+31:32i].
- req_x2  input  32*NREQ  operand 2, same slicing.
- resp_valid  output  1  result register holds a valid result.
- resp_ready  input  1  consumer accepts the result this cycle.
- resp_id  output  IDW  index of the requester that produced the result.
- resp_data  output  32  compare result, zero-extended: bit0 = result, bits 31:1 = 0.
- busy  output  1  resp_valid && !resp_ready (stall indicator).

Behaviour:
- Reset (rstn low, asynchronous):
  - resp_valid=0, resp_id=0, resp_data=0, req_ready=0.
  - Round-robin pointer rr_ptr=0.
  - Reset mid-transaction drops the held result without a handshake. Requesters must re-issue.
- Accept condition: can_accept = !resp_valid || resp_ready, evaluated combinationally.
- Grant, combinational:
  - When can_accept is set, exactly one req_ready bit is raised: the lowest index i at or above rr_ptr (cyclically) with req_valid[i]=1.
  - All other req_ready bits are 0.
  - If no request is valid, or can_accept=0, all req_ready bits are 0.
  - req_ready never depends on a requester's own req_valid except through the priority search.
- Pointer update: on an accepted request from index g, rr_ptr <= (g+1) mod NREQ. With no accept, rr_ptr holds.
- Latency: a request accepted in cycle t gives resp_valid=1 in cycle t+1, with resp_id=g and resp_data from operands sampled at t.
- Throughput: one result per cycle while resp_ready stays 1.
- Handshake:
  - If resp_ready=1 while resp_valid=1 and a new request is accepted in the same cycle, the register reloads and resp_valid stays 1.
  - If resp_ready=1 with no new accept, resp_valid falls to 0.
  - While busy, resp_id and resp_data are held stable.
- Compare arithmetic (pure bit logic, no real types):
  - Zero class: exponent=0 (zeros and denormals both treated as zero); +0 == -0.
  - NaN: exponent=255 with mantissa!=0. Any NaN operand gives result 0 for all ops.
  - Infinities compare by sign as ordinary extremes.
  - Non-NaN ordering: both zero gives equal. Otherwise sign decides; for equal signs, compare {exp,mant} as an unsigned magnitude, reversed for negatives.
  - feq = equal, flt = less, fle = less || equal.
- Boundaries:
  - All NREQ requesting continuously: grants rotate 0,1,2,...,NREQ-1,0 with no starvation.
  - A single requester asserting every cycle is granted every cycle.
  - rr_ptr wraps from NREQ-1 to 0.
  - A requester dropping req_valid before it is granted loses nothing; no state is kept per requester.
- Requester obligation: hold req_op, req_x1, req_x2 stable while req_valid=1 and req_ready=0.

Test Plan:
- Reset, then requester 0 issues fle with x1=32'h3F800000 (1.0), x2=32'h40000000 (2.0), resp_ready=1 -> next cycle resp_valid=1, resp_id=0, resp_data=1. Then flt with the operands swapped -> resp_data=0.
- Requester 2 issues feq with x1=32'h80000000, x2=32'h00000000 -> resp_data=1. fle with x1=32'h00000001 (denormal), x2=32'h80000000 -> 1. Any op with x1=32'h7FC00000 (NaN), x2=32'h3F800000 -> 0.
- All 4 requesters hold req_valid=1 from reset release with resp_ready=1 -> resp_id sequence 0,1,2,3,0,1, one per cycle. Exactly one req_ready bit high each cycle.
- Hold resp_ready=0 for 3 cycles after a result appears -> busy=1, all req_ready=0, and resp_id and resp_data held. Raise resp_ready -> the next grant loads in the same cycle, so resp_valid stays 1.
- Negative ordering: flt with x1=32'hC0000000 (-2.0), x2=32'hBF800000 (-1.0) -> 1. fle with x1=32'hFF800000 (-inf), x2=32'h7F800000 (+inf) -> 1. Op=11 -> 0.
- Assert rstn low asynchronously (mid-cycle) while resp_valid=1 and busy -> resp_valid drops to 0 immediately. After release, the first grant goes to the lowest valid index, since rr_ptr=0.

Source files
------------

// File: rtl/fcmp_sched_if.sv
// Request/response bundle for the shared FP compare scheduler.
// master = requesters plus result consumer, slave = the scheduler.
interface fcmp_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [2*NREQ-1:0]  req_op;
    logic [32*NREQ-1:0] req_x1;
    logic [32*NREQ-1:0] req_x2;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_data;
    logic               busy;

    modport master (
        output req_valid, req_op, req_x1, req_x2, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, busy
    );

    modport slave (
        input  req_valid, req_op, req_x1, req_x2, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, busy
    );
endinterface

// File: rtl/fcmp_sched.sv
// Round-robin scheduler feeding one single-precision feq/flt/fle datapath.
// One grant per cycle, result registered and held until the consumer takes it.
module fcmp_cmp (
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        res
);
    logic a_zero, b_zero, a_nan, b_nan, both_zero, eq, lt;
    logic [30:0] a_mag, b_mag;

    assign a_mag     = a[30:0];
    assign b_mag     = b[30:0];
    assign a_zero    = (a[30:23] == 8'h00);
    assign b_zero    = (b[30:23] == 8'h00);
    assign a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign both_zero = a_zero && b_zero;
    assign eq        = both_zero || (a == b);
    // Denormal magnitudes are always below any normal one, so they order correctly as zero.
    assign lt        = !both_zero &&
                       ((a[31] && !b[31]) ||
                        ((a[31] == b[31]) && (a[31] ? (b_mag < a_mag) : (a_mag < b_mag))));

    always_comb begin
        res = 1'b0;
        if (!a_nan && !b_nan) begin
            case (op)
                2'b00:   res = eq;
                2'b01:   res = lt;
                2'b10:   res = lt || eq;
                default: res = 1'b0;
            endcase
        end
    end
endmodule

module fcmp_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic        clk,
    input  logic        rstn,
    fcmp_sched_if.slave bus
);
    localparam int PW = IDW + 1;

    logic [NREQ-1:0][31:0] x1_l, x2_l;
    logic [NREQ-1:0][1:0]  op_l;
    logic [IDW-1:0]        rr_ptr, gidx, resp_id;
    logic [NREQ-1:0]       gnt;
    logic [PW-1:0]         cand;
    logic [31:0]           resp_data;
    logic                  found, can_accept, accept, cmp_res, resp_valid;

    assign x1_l = bus.req_x1;
    assign x2_l = bus.req_x2;
    assign op_l = bus.req_op;

    assign can_accept = !resp_valid || bus.resp_ready;
    assign accept     = found && can_accept;

    // Cyclic priority search starting at rr_ptr.
    always_comb begin
        gidx  = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'(rr_ptr) + PW'(k);
            if (cand >= PW'(NREQ))
                cand = cand - PW'(NREQ);
            if (!found && bus.req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                gidx  = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (accept && rstn)
            gnt[gidx] = 1'b1;
    end

    fcmp_cmp u_cmp (
        .op  (op_l[gidx]),
        .a   (x1_l[gidx]),
        .b   (x2_l[gidx]),
        .res (cmp_res)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else if (accept) begin
            rr_ptr     <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            resp_valid <= 1'b1;
            resp_id    <= gidx;
            resp_data  <= {31'd0, cmp_res};
        end else if (bus.resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_id    = resp_id;
    assign bus.resp_data  = resp_data;
    assign bus.busy       = resp_valid && !bus.resp_ready;
endmodule

// File: tb/tb_fcmp_sched.sv
// Directed and randomized checks of fcmp_sched against an ordering-key compare model
// and a queue-free round-robin reference.
module tb_fcmp_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fcmp_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    fcmp_sched #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    int             m_ptr;
    logic           m_valid;
    logic [IDW-1:0] m_id;
    logic [31:0]    m_data;
    int             m_gnt;

    logic [31:0] pool [10] = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h80000001,
                               32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h3F800000,
                               32'hBF800000, 32'h40000000};

    // Signed ordering key: zero class maps to 0, negatives mirror positives.
    function automatic longint key(input logic [31:0] v);
        if (v[30:23] == 8'h00) return 0;
        return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
    endfunction

    function automatic logic ref_cmp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ka, kb;
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 1'b0;
        ka = key(a);
        kb = key(b);
        case (op)
            2'b00:   return ka == kb;
            2'b01:   return ka < kb;
            2'b10:   return ka <= kb;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        if ($urandom_range(1) == 1) return pool[$urandom_range(9)];
        return $urandom;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_id    = '0;
        m_data  = '0;
        m_gnt   = -1;
    endtask

    // One clock: check grant/busy before the edge, then registered outputs after it.
    task automatic cycle();
        logic [NREQ-1:0] er;
        #1;
        m_gnt = -1;
        if (!m_valid || bus.resp_ready)
            for (int k = 0; k < NREQ; k++)
                if (m_gnt < 0 && bus.req_valid[(m_ptr + k) % NREQ]) m_gnt = (m_ptr + k) % NREQ;
        er = '0;
        if (m_gnt >= 0) er[m_gnt] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("busy", 64'(bus.busy), 64'(m_valid && !bus.resp_ready));
        @(posedge clk);
        #1;
        if (m_gnt >= 0) begin
            m_valid = 1'b1;
            m_id    = IDW'(m_gnt);
            m_data  = {31'd0, ref_cmp(bus.req_op[2*m_gnt +: 2], bus.req_x1[32*m_gnt +: 32],
                                      bus.req_x2[32*m_gnt +: 32])};
            m_ptr   = (m_gnt + 1) % NREQ;
        end else if (bus.resp_ready) begin
            m_valid = 1'b0;
        end
        chk("resp_valid", 64'(bus.resp_valid), 64'(m_valid));
        if (m_valid) begin
            chk("resp_id", 64'(bus.resp_id), 64'(m_id));
            chk("resp_data", 64'(bus.resp_data), 64'(m_data));
        end
    endtask

    task automatic issue(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic expd, input string tag);
        bus.req_valid           = '0;
        bus.req_valid[i]        = 1'b1;
        bus.req_op[2*i +: 2]    = op;
        bus.req_x1[32*i +: 32]  = a;
        bus.req_x2[32*i +: 32]  = b;
        bus.resp_ready          = 1'b1;
        cycle();
        chk(tag, 64'(bus.resp_data), 64'({31'd0, expd}));
        chk({tag, "_id"}, 64'(bus.resp_id), 64'(i));
        bus.req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [IDW-1:0] hid;
        logic [31:0]    hdata;
        logic           pend;

        model_reset();
        bus.req_valid  = '1;
        bus.req_op     = '0;
        bus.req_x1     = '0;
        bus.req_x2     = '0;
        bus.resp_ready = 1'b1;
        #2;
        chk("rst_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_id", 64'(bus.resp_id), 64'd0);
        chk("rst_data", 64'(bus.resp_data), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);

        // All requesters valid from reset release: strict rotation with wrap.
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rot_id", 64'(bus.resp_id), 64'(i % NREQ));
            chk("rot_onehot", 64'($countones(bus.req_ready)), 64'd1);
        end
        bus.req_valid = '0;
        cycle();

        issue(0, 2'b10, 32'h3F800000, 32'h40000000, 1'b1, "fle_1_2");
        issue(0, 2'b01, 32'h40000000, 32'h3F800000, 1'b0, "flt_2_1");
        issue(2, 2'b00, 32'h80000000, 32'h00000000, 1'b1, "feq_pm0");
        issue(2, 2'b10, 32'h00000001, 32'h80000000, 1'b1, "fle_denorm");
        issue(2, 2'b00, 32'h7FC00000, 32'h3F800000, 1'b0, "feq_nan");
        issue(2, 2'b01, 32'h7FC00000, 32'h3F800000, 1'b0, "flt_nan");
        issue(2, 2'b10, 32'h7FC00000, 32'h3F800000, 1'b0, "fle_nan");
        issue(1, 2'b01, 32'hC0000000, 32'hBF800000, 1'b1, "flt_neg");
        issue(1, 2'b10, 32'hFF800000, 32'h7F800000, 1'b1, "fle_inf");
        issue(3, 2'b11, 32'h3F800000, 32'h3F800000, 1'b0, "op_rsvd");
        cycle();

        // Backpressure: result held, no grants while busy, then reload on release.
        bus.req_valid  = '1;
        bus.resp_ready = 1'b1;
        cycle();
        hid   = bus.resp_id;
        hdata = bus.resp_data;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_busy", 64'(bus.busy), 64'd1);
            chk("hold_id", 64'(bus.resp_id), 64'(hid));
            chk("hold_data", 64'(bus.resp_data), 64'(hdata));
            chk("hold_noready", 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        cycle();
        chk("reload_valid", 64'(bus.resp_valid), 64'd1);

        // Asynchronous reset while busy.
        bus.resp_ready = 1'b0;
        cycle();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.resp_valid), 64'd0);
        chk("arst_ready", 64'(bus.req_ready), 64'd0);
        chk("arst_id", 64'(bus.resp_id), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        bus.req_valid  = 4'b0110;
        bus.resp_ready = 1'b1;
        rstn = 1'b1;
        cycle();
        chk("post_rst_id", 64'(bus.resp_id), 64'd1);

        // Randomized traffic obeying the hold-while-pending rule.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                pend = bus.req_valid[i] && (m_gnt != i);
                if (pend) begin
                    if ($urandom_range(9) == 0) bus.req_valid[i] = 1'b0;
                end else begin
                    bus.req_valid[i]       = ($urandom_range(4) < 3);
                    bus.req_op[2*i +: 2]   = 2'($urandom_range(3));
                    bus.req_x1[32*i +: 32] = rnd_val();
                    bus.req_x2[32*i +: 32] = ($urandom_range(3) == 0) ? bus.req_x1[32*i +: 32] : rnd_val();
                end
            end
            bus.resp_ready = ($urandom_range(3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
